// File: rtl/bg_sar_readout.sv
// bg_sar_readout: SAR controller that digitises the buffered bandgap reference,
// with optional averaging of 2^AVG_LOG2 conversions per reported result.
module bg_sar_readout #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             comp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid
);
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int CMAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [NW-1:0] CONV_LAST = NW'((1 << AVG_LOG2) - 1);
    localparam logic [IW-1:0] TOP_BIT   = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB    = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, BIT, DONE} state_t;

    state_t           state_q;
    logic             sync1_q, comp_s_q;
    logic [CW-1:0]    cyc_q;
    logic [IW-1:0]    bit_q;
    logic [AW-1:0]    acc_q;
    logic [NW-1:0]    conv_q;
    logic             sample_en_q, valid_q;
    logic [WIDTH-1:0] dac_q, result_q;
    logic [WIDTH-1:0] trial_mask, code_d;
    logic [AW-1:0]    acc_d;

    assign trial_mask = WIDTH'(1) << bit_q;
    // the trial bit survives only if the synchronised comparator saw Vin >= Vdac
    assign code_d     = comp_s_q ? dac_q : (dac_q & ~trial_mask);
    assign acc_d      = acc_q + AW'(code_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            comp_s_q <= 1'b0;
        end else begin
            sync1_q  <= comp_in;
            comp_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            acc_q       <= '0;
            conv_q      <= '0;
            sample_en_q <= 1'b0;
            dac_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!ena) begin
                state_q     <= IDLE;
                cyc_q       <= '0;
                acc_q       <= '0;
                conv_q      <= '0;
                sample_en_q <= 1'b0;
                dac_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q     <= SAMPLE;
                        cyc_q       <= '0;
                        acc_q       <= '0;
                        conv_q      <= '0;
                        sample_en_q <= 1'b1;
                        dac_q       <= '0;
                    end
                    SAMPLE: if (cyc_q == SAMP_LAST) begin
                        state_q     <= BIT;
                        cyc_q       <= '0;
                        bit_q       <= TOP_BIT;
                        sample_en_q <= 1'b0;
                        dac_q       <= MSB;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                    BIT: if (cyc_q == SET_LAST) begin
                        cyc_q <= '0;
                        if (bit_q != '0) begin
                            bit_q <= bit_q - IW'(1);
                            dac_q <= code_d | (trial_mask >> 1);
                        end else begin
                            acc_q  <= acc_d;
                            conv_q <= conv_q + NW'(1);
                            dac_q  <= '0;
                            if (conv_q == CONV_LAST) begin
                                state_q <= DONE;
                            end else begin
                                state_q     <= SAMPLE;
                                sample_en_q <= 1'b1;
                            end
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                    DONE: begin
                        state_q  <= IDLE;
                        result_q <= acc_q[AW-1:AVG_LOG2];
                        valid_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample_en = sample_en_q;
    assign dac_code  = dac_q;
    assign busy      = state_q != IDLE;
    assign result    = result_q;
    assign valid     = valid_q;
endmodule

// File: tb/tb_bg_sar_readout.sv
// tb_bg_sar_readout: directed bench for the bandgap SAR readout, single-shot and averaged.
`timescale 1ns/1ps
module tb_bg_sar_readout;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] vin0 = 8'h00, vin1 = 8'h00;
    logic       comp0, comp1;
    logic       se0, se1, busy0, busy1, val0, val1;
    logic [7:0] dac0, dac1, res0, res1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign comp0 = (vin0 >= dac0);
    assign comp1 = (vin1 >= dac1);

    bg_sar_readout u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start0), .comp_in(comp0),
        .sample_en(se0), .dac_code(dac0), .busy(busy0), .result(res0), .valid(val0)
    );

    bg_sar_readout #(.AVG_LOG2(2)) u_avg (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .comp_in(comp1),
        .sample_en(se1), .dac_code(dac1), .busy(busy1), .result(res1), .valid(val1)
    );

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    // Runs one conversion on the default DUT; lat is cycles from the start-sampling edge.
    task automatic convert0(input logic [7:0] v, output int lat, output int nval, output logic [7:0] res);
        vin0 = v; lat = -1; nval = 0; res = 8'hxx;
        pulse_start0();
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (val0) begin
                nval++;
                if (lat < 0) begin lat = c; res = res0; end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({se0, dac0, busy0, res0, val0} !== 19'd0) begin failures++; $display("FAIL reset_outputs got %h exp 0", {se0, dac0, busy0, res0, val0}); end
        checks++; if ({se1, dac1, busy1, res1, val1} !== 19'd0) begin failures++; $display("FAIL reset_outputs_avg got %h exp 0", {se1, dac1, busy1, res1, val1}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h98, 8'h9C, 8'h9E, 8'h9D};
        logic [7:0] got [8];
        int se_cnt, lat, nval, overlap;
        vin0 = 8'h9C; lat = -1; nval = 0; overlap = 0;
        pulse_start0();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy got %b exp 1", busy0); end
        se_cnt = se0 ? 1 : 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (se0) se_cnt++;
            if (c >= 4 && c <= 32 && (c - 4) % 4 == 0) got[(c - 4) / 4] = dac0;
            if (val0) begin
                nval++;
                if (lat < 0) lat = c;
                if (se0) overlap++;
            end
        end
        checks++; if (se_cnt !== 4) begin failures++; $display("FAIL basic_sample_cycles got %0d exp 4", se_cnt); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (got[k] !== seq[k]) begin failures++; $display("FAIL basic_trial%0d got %h exp %h", k, got[k], seq[k]); end
        end
        checks++; if (lat !== 37) begin failures++; $display("FAIL basic_latency got %0d exp 37", lat); end
        checks++; if (nval !== 1) begin failures++; $display("FAIL basic_valid_count got %0d exp 1", nval); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL basic_valid_sample_overlap got %0d exp 0", overlap); end
        checks++; if (res0 !== 8'h9C) begin failures++; $display("FAIL basic_result got %h exp 9c", res0); end
        checks++; if ({busy0, dac0} !== 9'd0) begin failures++; $display("FAIL basic_idle_after got %h exp 0", {busy0, dac0}); end
    endtask

    task automatic test_boundaries();
        int lat, nval;
        logic [7:0] res;
        convert0(8'hFF, lat, nval, res);
        checks++; if (lat !== 37) begin failures++; $display("FAIL ff_latency got %0d exp 37", lat); end
        checks++; if (res !== 8'hFF) begin failures++; $display("FAIL ff_result got %h exp ff", res); end
        convert0(8'h00, lat, nval, res);
        checks++; if (lat !== 37) begin failures++; $display("FAIL zero_latency got %0d exp 37", lat); end
        checks++; if (res !== 8'h00) begin failures++; $display("FAIL zero_result got %h exp 00", res); end
        checks++; if (nval !== 1) begin failures++; $display("FAIL zero_valid_count got %0d exp 1", nval); end
    endtask

    task automatic test_avg();
        int lat = -1, nval = 0, overlap = 0;
        logic [7:0] res = 8'hxx;
        vin1 = 8'h80;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            @(posedge clk); #1;
            if (c == 36) vin1 = 8'h81;
            if (c == 72) vin1 = 8'h81;
            if (c == 108) vin1 = 8'h82;
            if (val1) begin
                nval++;
                if (lat < 0) begin lat = c; res = res1; end
                if (se1) overlap++;
            end
        end
        checks++; if (lat !== 145) begin failures++; $display("FAIL avg_latency got %0d exp 145", lat); end
        checks++; if (res !== 8'h81) begin failures++; $display("FAIL avg_result got %h exp 81", res); end
        checks++; if (nval !== 1) begin failures++; $display("FAIL avg_valid_count got %0d exp 1", nval); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL avg_valid_sample_overlap got %0d exp 0", overlap); end
    endtask

    task automatic test_back_to_back();
        int lat = -1, nval = 0;
        logic [7:0] res = 8'hxx;
        vin0 = 8'h5A;
        pulse_start0();
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start0 = (c == 9);
            if (val0) begin
                nval++;
                if (lat < 0) begin lat = c; res = res0; end
            end
        end
        checks++; if (nval !== 1) begin failures++; $display("FAIL b2b_valid_count got %0d exp 1", nval); end
        checks++; if (lat !== 37) begin failures++; $display("FAIL b2b_latency got %0d exp 37", lat); end
        checks++; if (res !== 8'h5A) begin failures++; $display("FAIL b2b_result got %h exp 5a", res); end
        convert0(8'h9C, lat, nval, res);
        checks++; if (lat !== 37) begin failures++; $display("FAIL b2b_restart_latency got %0d exp 37", lat); end
        checks++; if (res !== 8'h9C) begin failures++; $display("FAIL b2b_restart_result got %h exp 9c", res); end
    endtask

    task automatic test_ena_abort();
        int nval = 0;
        vin0 = 8'h33;
        pulse_start0();
        repeat (9) @(posedge clk);
        #1 ena = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy0, se0, dac0} !== 10'd0) begin failures++; $display("FAIL abort_idle got %h exp 0", {busy0, se0, dac0}); end
        ena = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (val0) nval++;
        end
        checks++; if (nval !== 0) begin failures++; $display("FAIL abort_no_valid got %0d exp 0", nval); end
        checks++; if (res0 !== 8'h9C) begin failures++; $display("FAIL abort_result_kept got %h exp 9c", res0); end
        ena = 1'b0;
        pulse_start0();
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL start_with_ena_low got %b exp 0", busy0); end
        ena = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL start_with_ena_low_late got %b exp 0", busy0); end
    endtask

    task automatic test_rst_mid();
        int lat, nval;
        logic [7:0] res;
        vin0 = 8'h9C;
        pulse_start0();
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({se0, dac0, busy0, res0, val0} !== 19'd0) begin failures++; $display("FAIL rst_mid_outputs got %h exp 0", {se0, dac0, busy0, res0, val0}); end
        @(posedge clk); #1 rst_n = 1'b1;
        convert0(8'h37, lat, nval, res);
        checks++; if (lat !== 37) begin failures++; $display("FAIL rst_fresh_latency got %0d exp 37", lat); end
        checks++; if (res !== 8'h37) begin failures++; $display("FAIL rst_fresh_result got %h exp 37", res); end
        checks++; if (nval !== 1) begin failures++; $display("FAIL rst_fresh_valid_count got %0d exp 1", nval); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_avg();
        test_back_to_back();
        test_ena_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
